// File: rtl/riscv_pkg.sv
// riscv_pkg: shared width, NOP encoding and fetch FSM state type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  typedef enum logic [1:0] {REQ, HOLD, DRAIN, FAULT} fetch_state_e;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: XLEN-wide enable register (clk, reset_n, en, d -> q), async active-low reset to RESET_PC
module pc_reg #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= RESET_PC;
    else if (en) q <= d;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns PC, drives imem req/addr (ack/rdata in), presents out_{pc,pc4,insn} via valid/ready, takes redirects, traps misaligned targets on out_fault
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc4,
  output logic [31:0]     out_insn,
  output logic            out_fault
);
  fetch_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d, tgt_pc, pc4;
  logic pend_fault_q, pend_fault_d, tgt_flt, aligned, pc_en, cap, valid_q, valid_d;
  pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .reset_n(reset_n), .en(pc_en), .d(pc_d), .q(pc_q)
  );
  assign pc4 = pc_q + XLEN'(4);
  assign aligned = redirect_pc[1:0] == 2'b00;
  assign tgt_pc = redirect ? redirect_pc : pend_pc_q;
  assign tgt_flt = redirect ? !aligned : pend_fault_q;
  assign imem_req = reset_n && (state_q == REQ || state_q == DRAIN);
  assign imem_addr = pc_q;
  assign out_valid = valid_q;
  assign out_fault = state_q == FAULT;
  always_comb begin
    state_d = state_q;
    pc_en = 1'b0;
    pc_d = pc4;
    pend_pc_d = pend_pc_q;
    pend_fault_d = pend_fault_q;
    cap = 1'b0;
    valid_d = valid_q;
    case (state_q)
      REQ:
        if (redirect) begin
          valid_d = 1'b0;
          pend_pc_d = redirect_pc;
          pend_fault_d = !aligned;
          pc_en = imem_ack && aligned;
          pc_d = redirect_pc;
          state_d = !imem_ack ? DRAIN : aligned ? REQ : FAULT;
        end else if (imem_ack) begin
          cap = 1'b1;
          valid_d = 1'b1;
          pc_en = 1'b1;
          state_d = HOLD;
        end
      HOLD:
        if (redirect) begin
          valid_d = 1'b0;
          pc_en = aligned;
          pc_d = redirect_pc;
          state_d = aligned ? REQ : FAULT;
        end else if (out_ready) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      DRAIN: begin
        pend_pc_d = tgt_pc;
        pend_fault_d = tgt_flt;
        if (imem_ack) begin
          pc_en = !tgt_flt;
          pc_d = tgt_pc;
          state_d = tgt_flt ? FAULT : REQ;
        end
      end
      default:
        if (redirect && aligned) begin
          pc_en = 1'b1;
          pc_d = redirect_pc;
          state_d = REQ;
        end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= REQ;
      valid_q <= 1'b0;
      out_pc <= '0;
      out_pc4 <= '0;
      out_insn <= NOP_INSN;
      pend_pc_q <= '0;
      pend_fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      pend_pc_q <= pend_pc_d;
      pend_fault_q <= pend_fault_d;
      if (cap) begin
        out_pc <= pc_q;
        out_pc4 <= pc4;
        out_insn <= imem_rdata;
      end
    end
endmodule
